vv_batch_engine: RTL and testbench

Batched dot-product engine: computes up to NUM_VEC independent N-element dot products in one run, storing each result at its own address in an internal result memory. It owns its vector-A, vector-B and result memories, the run-control FSM and a bubble-free multiply-accumulate datapath. A host loads operands through write ports, pulses `start`, waits for `done`, then reads results back. It extends the single-result vector multiplier with runtime batch count, signed mode, busy/done handshake and result count.

---
 rtl/vv_batch_engine.sv | 157 +++++++++++++++
 tb/tb_vv_batch_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vv_batch_engine.sv
// Batched dot-product engine: up to NUM_VEC N-element dot products per run,
// fed from internal A/B operand memories, results stored per vector index.
module vv_batch_engine #(
  parameter int N          = 4,
  parameter int DW         = 8,
  parameter int NUM_VEC    = 4,
  parameter int BRAM_DEPTH = 32,
  parameter int SIGNED     = 0,
  localparam int AW  = $clog2(BRAM_DEPTH),
  localparam int RW  = 2*DW + $clog2(N),
  localparam int VW  = $clog2(NUM_VEC+1),
  localparam int RAW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [VW-1:0]  num_vec,
  input  logic           vec_a_we,
  input  logic [AW-1:0]  vec_a_wr_addr,
  input  logic [DW-1:0]  vec_a_wr_data,
  input  logic           vec_b_we,
  input  logic [AW-1:0]  vec_b_wr_addr,
  input  logic [DW-1:0]  vec_b_wr_data,
  input  logic [RAW-1:0] res_rd_addr,
  output logic [RW-1:0]  res_rd_data,
  output logic           busy,
  output logic           done,
  output logic [VW-1:0]  res_count
);

  localparam int EW = $clog2(N);
  localparam logic [EW-1:0] LAST_E  = EW'(N-1);
  localparam logic [VW-1:0] ONE_V   = VW'(1);
  localparam logic [VW-1:0] MAX_V   = VW'(NUM_VEC);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]        a_mem [BRAM_DEPTH];
  logic [DW-1:0]        b_mem [BRAM_DEPTH];
  logic signed [RW-1:0] res_mem [NUM_VEC];

  logic [VW-1:0] n_eff, n_clamp;
  logic [AW-1:0] addr_p0;
  logic [EW-1:0] elem_p0;
  logic [VW-1:0] vec_p0;
  logic          vld_p0;

  logic [DW-1:0] a_p1, b_p1;
  logic          first_p1, last_p1, vld_p1;
  logic [VW-1:0] vidx_p1;

  logic signed [RW-1:0] acc, prod;
  logic issue_last, final_wr, fin;

  // Full-precision product extended to result width per operand mode.
  function automatic logic signed [RW-1:0] mult(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] ps;
    logic [2*DW-1:0]        pu;
    ps = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    pu = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    if (SIGNED != 0) mult = {{(RW-2*DW){ps[2*DW-1]}}, ps};
    else             mult = {{(RW-2*DW){1'b0}}, pu};
  endfunction

  assign n_clamp    = (num_vec > MAX_V) ? MAX_V : num_vec;
  assign issue_last = vld_p0 && (elem_p0 == LAST_E) && (vec_p0 == n_eff - ONE_V);
  assign final_wr   = vld_p1 && last_p1 && (vidx_p1 == n_eff - ONE_V);
  assign fin        = (state == FINISH) && ((n_eff == '0) || final_wr);
  assign prod       = mult(a_p1, b_p1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_clamp == '0) ? FINISH : RUN;
      RUN:     if (issue_last) state_nxt = FINISH;
      FINISH:  if (fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: address issue and run control
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_eff     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_count <= '0;
      addr_p0   <= '0;
      elem_p0   <= '0;
      vec_p0    <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= fin;
      vld_p1 <= vld_p0;
      if (state == IDLE && start) begin
        n_eff     <= n_clamp;
        addr_p0   <= '0;
        elem_p0   <= '0;
        vec_p0    <= '0;
        vld_p0    <= (n_clamp != '0);
        busy      <= (n_clamp != '0);
        res_count <= '0;
      end else if (state == RUN) begin
        if (issue_last) begin
          vld_p0 <= 1'b0;
        end else begin
          addr_p0 <= addr_p0 + AW'(1);
          if (elem_p0 == LAST_E) begin
            elem_p0 <= '0;
            vec_p0  <= vec_p0 + ONE_V;
          end else begin
            elem_p0 <= elem_p0 + EW'(1);
          end
        end
      end
      if (fin) busy <= 1'b0;
      if (vld_p1 && last_p1) res_count <= res_count + ONE_V;
    end
  end

  // Stage p1: operand memory read
  always_ff @(posedge clk) begin
    a_p1     <= a_mem[addr_p0];
    b_p1     <= b_mem[addr_p0];
    first_p1 <= (elem_p0 == '0);
    last_p1  <= (elem_p0 == LAST_E);
    vidx_p1  <= vec_p0;
  end

  always_ff @(posedge clk) begin
    if (vec_a_we && !busy) a_mem[vec_a_wr_addr] <= vec_a_wr_data;
    if (vec_b_we && !busy) b_mem[vec_b_wr_addr] <= vec_b_wr_data;
  end

  // Stage p2: accumulate; last element goes straight to result memory
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (vld_p1) begin
      acc <= first_p1 ? prod : acc + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && vld_p1 && last_p1) res_mem[vidx_p1[RAW-1:0]] <= acc + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) res_rd_data <= '0;
    else     res_rd_data <= res_mem[res_rd_addr];
  end

endmodule

// File: tb/tb_vv_batch_engine.sv
// Bench for vv_batch_engine: unsigned and signed instances share stimulus,
// checked against constant tables and a sum-of-products reference model.
module tb_vv_batch_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  num_vec = '0;
  logic        vec_a_we = 1'b0, vec_b_we = 1'b0;
  logic [4:0]  vec_a_wr_addr = '0, vec_b_wr_addr = '0;
  logic [7:0]  vec_a_wr_data = '0, vec_b_wr_data = '0;
  logic [1:0]  res_rd_addr = '0;
  logic [17:0] res_rd_data_u, res_rd_data_s;
  logic        busy_u, busy_s, done_u, done_s;
  logic [2:0]  res_count_u, res_count_s;

  always #5 clk = ~clk;

  vv_batch_engine #(.N(4), .DW(8), .NUM_VEC(4), .BRAM_DEPTH(32), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .vec_a_we(vec_a_we), .vec_a_wr_addr(vec_a_wr_addr), .vec_a_wr_data(vec_a_wr_data),
    .vec_b_we(vec_b_we), .vec_b_wr_addr(vec_b_wr_addr), .vec_b_wr_data(vec_b_wr_data),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data_u),
    .busy(busy_u), .done(done_u), .res_count(res_count_u));

  vv_batch_engine #(.N(4), .DW(8), .NUM_VEC(4), .BRAM_DEPTH(32), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .vec_a_we(vec_a_we), .vec_a_wr_addr(vec_a_wr_addr), .vec_a_wr_data(vec_a_wr_data),
    .vec_b_we(vec_b_we), .vec_b_wr_addr(vec_b_wr_addr), .vec_b_wr_data(vec_b_wr_data),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data_s),
    .busy(busy_s), .done(done_s), .res_count(res_count_s));

  int errors = 0;
  int checks = 0;

  logic [7:0] ma [32];
  logic [7:0] mb [32];
  int         ram_u [4];
  int         ram_s [4];
  bit         ram_vld [4];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          exp_u;
    int          exp_s;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference dot product of vector k, reduced modulo 2^18.
  function automatic int dot(input int k, input bit sgn);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      if (sgn) s += int'($signed(ma[k*4+i])) * int'($signed(mb[k*4+i]));
      else     s += int'(ma[k*4+i]) * int'(mb[k*4+i]);
    end
    return s & 32'h3FFFF;
  endfunction

  task automatic write_op(input int addr, input logic [7:0] a, input logic [7:0] b);
    vec_a_we = 1'b1; vec_b_we = 1'b1;
    vec_a_wr_addr = 5'(addr); vec_b_wr_addr = 5'(addr);
    vec_a_wr_data = a; vec_b_wr_data = b;
    @(posedge clk); #1;
    vec_a_we = 1'b0; vec_b_we = 1'b0;
    ma[addr] = a; mb[addr] = b;
  endtask

  task automatic load_vec(input int k, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) write_op(k*4+i, a[8*i +: 8], b[8*i +: 8]);
  endtask

  task automatic rd(input int k, output int u, output int s);
    res_rd_addr = 2'(k);
    @(posedge clk); #1;
    u = int'(res_rd_data_u);
    s = int'(res_rd_data_s);
  endtask

  task automatic check_ram();
    int u, s;
    for (int k = 0; k < 4; k++) begin
      if (ram_vld[k]) begin
        rd(k, u, s);
        chk($sformatf("ram_u[%0d]", k), u, ram_u[k]);
        chk($sformatf("ram_s[%0d]", k), s, ram_s[k]);
      end
    end
  endtask

  // Start a run and watch busy/done/res_count every cycle against the timing rules.
  task automatic run(input int nv, input bit inject);
    int ne, tdone, ecnt;
    ne    = (nv > 4) ? 4 : nv;
    tdone = (ne == 0) ? 1 : ne*4 + 1;
    start = 1'b1; num_vec = 3'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_e0_u", int'(busy_u), int'(ne != 0));
    chk("busy_e0_s", int'(busy_s), int'(ne != 0));
    chk("done_e0_u", int'(done_u), 0);
    for (int c = 1; c <= tdone + 2; c++) begin
      if (inject && c == 2) begin
        start = 1'b1; num_vec = 3'd1;
        vec_a_we = 1'b1; vec_b_we = 1'b1;
        vec_a_wr_addr = 5'd0; vec_b_wr_addr = 5'd0;
        vec_a_wr_data = ~ma[0]; vec_b_wr_data = ~mb[0];
      end
      @(posedge clk); #1;
      start = 1'b0; vec_a_we = 1'b0; vec_b_we = 1'b0;
      ecnt = (c - 1) / 4;
      if (ecnt > ne) ecnt = ne;
      chk($sformatf("busy_u c%0d", c), int'(busy_u), int'(ne != 0 && c < tdone));
      chk($sformatf("busy_s c%0d", c), int'(busy_s), int'(ne != 0 && c < tdone));
      chk($sformatf("done_u c%0d", c), int'(done_u), int'(c == tdone));
      chk($sformatf("done_s c%0d", c), int'(done_s), int'(c == tdone));
      chk($sformatf("cnt_u c%0d", c), int'(res_count_u), ecnt);
      chk($sformatf("cnt_s c%0d", c), int'(res_count_s), ecnt);
    end
    for (int k = 0; k < ne; k++) begin
      ram_u[k] = dot(k, 1'b0);
      ram_s[k] = dot(k, 1'b1);
      ram_vld[k] = 1'b1;
    end
  endtask

  initial begin
    int u, s;
    tbl[0] = '{32'h04030201, 32'h08070605, 70, 70};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 260100, 4};
    tbl[2] = '{32'h80808080, 32'h80808080, 65536, 65536};
    tbl[3] = '{32'h000000FB, 32'h00000003, 753, 32'h3FFF1};
    tbl[4] = '{32'h7F7F7F7F, 32'h80808080, 65024, 197120};
    for (int k = 0; k < 4; k++) ram_vld[k] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_u | busy_s), 0);
    chk("rst_done", int'(done_u | done_s), 0);
    chk("rst_cnt_u", int'(res_count_u), 0);
    chk("rst_cnt_s", int'(res_count_s), 0);
    chk("rst_rd_u", int'(res_rd_data_u), 0);
    chk("rst_rd_s", int'(res_rd_data_s), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      load_vec(0, tbl[t].a, tbl[t].b);
      run(1, 1'b0);
      rd(0, u, s);
      chk($sformatf("tbl%0d_u", t), u, tbl[t].exp_u);
      chk($sformatf("tbl%0d_s", t), s, tbl[t].exp_s);
    end

    // Back-to-back vectors: no accumulator carry-over between them
    load_vec(0, 32'h01010101, 32'h01010101);
    load_vec(1, 32'h02020202, 32'h03030303);
    load_vec(2, 32'h00000000, 32'h00000000);
    run(3, 1'b0);
    rd(0, u, s); chk("b2b0", u, 4);
    rd(1, u, s); chk("b2b1", u, 24);
    rd(2, u, s); chk("b2b2", u, 0);
    check_ram();

    // Zero vectors: immediate done, nothing written
    load_vec(0, 32'h05050505, 32'h05050505);
    run(0, 1'b0);
    check_ram();

    // Clamp to NUM_VEC with random operands
    for (int i = 0; i < 16; i++) write_op(i, 8'($urandom), 8'($urandom));
    run(7, 1'b0);
    check_ram();

    // start and operand writes during busy are ignored
    run(2, 1'b1);
    check_ram();
    run(2, 1'b0);
    check_ram();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) write_op(i, 8'($urandom), 8'($urandom));
      run(int'($urandom_range(0, 7)), 1'b0);
      check_ram();
    end

    // Abort mid-run: first result kept, later ones untouched
    load_vec(0, 32'h01010101, 32'h03030303);
    load_vec(1, 32'h02020202, 32'h03030303);
    load_vec(2, 32'h00000000, 32'h00000000);
    start = 1'b1; num_vec = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_cnt_pre", int'(res_count_u), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy_u | busy_s), 0);
    chk("abort_done", int'(done_u | done_s), 0);
    chk("abort_cnt", int'(res_count_u), 0);
    chk("abort_rd", int'(res_rd_data_u), 0);
    rst = 1'b0;
    ram_u[0] = 12; ram_s[0] = 12; ram_vld[0] = 1'b1;
    check_ram();
    run(3, 1'b0);
    check_ram();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
